// File: rtl/hpi_txn_ctrl.sv
// hpi_txn_ctrl: sequences CY7C67200 HPI accesses through a registered pad interface.
// A register op is one access phase on cmd_reg. A memory op is two phases: write cmd_addr
// to ADDRESS (2), then read/write DATA (0). Every phase is SETUP -> STROBE -> HOLD -> RECOVER.
//
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_* fields latched on acceptance
//   cmd_write, cmd_mem    1 = write / 1 = memory op
//   cmd_reg               HPI register for a register op
//   cmd_addr, cmd_wdata   memory address and write data
//   rsp_valid, rsp_rdata  one-cycle completion pulse and read result
//   hpi_address, hpi_data_out, hpi_data_in, hpi_r, hpi_w, hpi_cs   pad interface
module hpi_txn_ctrl #(
    parameter int unsigned STROBE_CYCLES  = 4,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_mem,
    input  logic [1:0]  cmd_reg,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover,
        StDone
    } state_e;

    localparam logic [3:0] StrobeLoad  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RecoverLoad = 4'(RECOVER_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;   // 0 = first phase, 1 = DATA phase of a memory op
    logic        write_q, write_d;
    logic        mem_q, mem_d;
    logic [1:0]  reg_q, reg_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    // Attributes of the phase being entered; outputs are registered from these.
    logic        ph_write_d;
    logic [1:0]  ph_reg_d;
    logic [15:0] ph_wdata_d;
    logic        active_d;
    logic        strobe_d;
    // Whether the phase currently in progress is a read.
    logic        cur_read;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        write_d = write_q;
        mem_d   = mem_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = StSetup;
                    phase_d = 1'b0;
                    write_d = cmd_write;
                    mem_d   = cmd_mem;
                    reg_d   = cmd_reg;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                end
            end
            StSetup: begin
                state_d = StStrobe;
                cnt_d   = StrobeLoad;
            end
            StStrobe: begin
                if (cnt_q == 4'd0) state_d = StHold;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StHold: begin
                state_d = StRecover;
                cnt_d   = RecoverLoad;
            end
            StRecover: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (mem_q && !phase_q) begin
                    state_d = StSetup;
                    phase_d = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // The address phase of a memory op is always a write of cmd_addr to ADDRESS.
        ph_write_d = (mem_d && !phase_d) ? 1'b1 : write_d;
        ph_reg_d   = mem_d ? (phase_d ? 2'd0 : 2'd2) : reg_d;
        ph_wdata_d = (mem_d && !phase_d) ? addr_d : wdata_d;
        active_d   = state_d inside {StSetup, StStrobe, StHold};
        strobe_d   = (state_d == StStrobe);
        cur_read   = !((mem_q && !phase_q) || write_q);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            phase_q      <= 1'b0;
            write_q      <= 1'b0;
            mem_q        <= 1'b0;
            reg_q        <= 2'd0;
            addr_q       <= 16'd0;
            wdata_q      <= 16'd0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 16'd0;
            hpi_address  <= 2'd0;
            hpi_data_out <= 16'd0;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
            hpi_cs       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            write_q      <= write_d;
            mem_q        <= mem_d;
            reg_q        <= reg_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cmd_ready    <= (state_d == StIdle);
            rsp_valid    <= (state_d == StDone);
            hpi_cs       <= !active_d;
            hpi_address  <= active_d ? ph_reg_d : 2'd0;
            hpi_data_out <= (active_d && ph_write_d) ? ph_wdata_d : 16'd0;
            hpi_r        <= !(strobe_d && !ph_write_d);
            hpi_w        <= !(strobe_d && ph_write_d);
            // The pad registers the strobe out and the data back in, so read data is
            // valid by the end of HOLD.
            if (state_q == StHold && cur_read) rsp_rdata <= hpi_data_in;
        end
    end

endmodule

// File: tb/tb_hpi_txn_ctrl.sv
module tb_hpi_txn_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic        cmd_mem = 1'b0;
    logic [1:0]  cmd_reg = 2'd0;
    logic [15:0] cmd_addr = 16'd0;
    logic [15:0] cmd_wdata = 16'd0;
    logic        sel = 1'b0;   // 0: default-parameter DUT, 1: STROBE=1/RECOVER=1 DUT
    logic [15:0] pad_val = 16'd0;

    logic        cmd_valid_a, cmd_valid_b;
    logic        ready_a, ready_b, valid_a, valid_b;
    logic [15:0] rdata_a, rdata_b, dout_a, dout_b;
    logic [15:0] din_a = 16'd0, din_b = 16'd0;
    logic [1:0]  addr_a, addr_b;
    logic        r_a, r_b, w_a, w_b, cs_a, cs_b;
    logic        cs_pad_a = 1'b1, cs_pad_b = 1'b1;

    assign cmd_valid_a = cmd_valid && !sel;
    assign cmd_valid_b = cmd_valid && sel;

    hpi_txn_ctrl dut_a (
        .Clk(Clk), .Reset_n(Reset_n), .cmd_valid(cmd_valid_a), .cmd_ready(ready_a),
        .cmd_write(cmd_write), .cmd_mem(cmd_mem), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(valid_a), .rsp_rdata(rdata_a),
        .hpi_address(addr_a), .hpi_data_out(dout_a), .hpi_data_in(din_a),
        .hpi_r(r_a), .hpi_w(w_a), .hpi_cs(cs_a)
    );

    hpi_txn_ctrl #(.STROBE_CYCLES(1), .RECOVER_CYCLES(1)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .cmd_valid(cmd_valid_b), .cmd_ready(ready_b),
        .cmd_write(cmd_write), .cmd_mem(cmd_mem), .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(valid_b), .rsp_rdata(rdata_b),
        .hpi_address(addr_b), .hpi_data_out(dout_b), .hpi_data_in(din_b),
        .hpi_r(r_b), .hpi_w(w_b), .hpi_cs(cs_b)
    );

    always #5 Clk = ~Clk;

    // Pad model: chip-select goes out through one register, the chip drives its data while
    // selected, and that data comes back through another register. Garbage otherwise.
    always @(posedge Clk) begin
        cs_pad_a <= cs_a;
        cs_pad_b <= cs_b;
        din_a    <= (cs_pad_a === 1'b0) ? pad_val : 16'($urandom);
        din_b    <= (cs_pad_b === 1'b0) ? pad_val : 16'($urandom);
    end

    // {cs, r, w, address, data_out, rsp_valid, cmd_ready}
    logic [21:0] obs;
    logic [15:0] obs_rdata;
    assign obs = sel ? {cs_b, r_b, w_b, addr_b, dout_b, valid_b, ready_b}
                     : {cs_a, r_a, w_a, addr_a, dout_a, valid_a, ready_a};
    assign obs_rdata = sel ? rdata_b : rdata_a;

    localparam logic [21:0] ResetPins = {3'b111, 2'b00, 16'h0, 1'b0, 1'b0};
    localparam logic [21:0] IdlePins  = {3'b111, 2'b00, 16'h0, 1'b0, 1'b1};

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] exp_rdata [2];

    function automatic int stb_len(input logic s);
        return s ? 1 : 4;
    endfunction

    function automatic int rec_len(input logic s);
        return s ? 1 : 2;
    endfunction

    // Expected pins at cycle c (acceptance edge = cycle 0) for an op finishing at cycle n.
    function automatic logic [21:0] exp_pins(input int c, input int n, input int s, input int r,
                                             input bit wr, input bit mem, input logic [1:0] rg,
                                             input logic [15:0] ad, input logic [15:0] wd);
        int l, p, o;
        bit pw, act, stb;
        logic [1:0] pa;
        logic [15:0] pd;
        if (c == n) return {3'b111, 2'b00, 16'h0, 1'b1, 1'b0};
        if (c > n) return IdlePins;
        l = s + r + 2;
        p = (c - 1) / l;
        o = (c - 1) % l;
        if (mem && p == 0) begin
            pw = 1'b1; pa = 2'd2; pd = ad;
        end else if (mem) begin
            pw = wr; pa = 2'd0; pd = wd;
        end else begin
            pw = wr; pa = rg; pd = wd;
        end
        act = (o <= s + 1);
        stb = (o >= 1) && (o <= s);
        return {~act, ~(stb && !pw), ~(stb && pw), act ? pa : 2'b00,
                (act && pw) ? pd : 16'h0, 1'b0, 1'b0};
    endfunction

    // Issue one op on the DUT picked by sel and check every cycle up to the IDLE after DONE.
    // Must be called away from a rising edge.
    task automatic run_op(input bit wr, input bit mem, input logic [1:0] rg,
                          input logic [15:0] ad, input logic [15:0] wd, input logic [15:0] rd,
                          input string name);
        int s, r, n;
        bit seen;
        logic [21:0] exp;
        s = stb_len(sel);
        r = rec_len(sel);
        n = (mem ? 2 : 1) * (s + r + 2) + 1;
        seen = 1'b0;
        pad_val = rd;
        cmd_write = wr; cmd_mem = mem; cmd_reg = rg; cmd_addr = ad; cmd_wdata = wd;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (obs[0] === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge Clk);
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s accept: cmd_ready=%b, required 1 within 50 cycles", name, obs[0]);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        #1;
        // Inputs change after acceptance; the op must keep its latched fields.
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_mem = 1'($urandom); cmd_reg = 2'($urandom);
        cmd_addr = 16'($urandom); cmd_wdata = 16'($urandom);
        if (!wr) exp_rdata[sel] = rd;
        for (int c = 1; c <= n + 1; c++) begin
            @(negedge Clk);
            exp = exp_pins(c, n, s, r, wr, mem, rg, ad, wd);
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s pins cycle %0d: got %h, required %h", name, c, obs, exp);
            end
            if (c == n) begin
                n_cmp++;
                if (obs_rdata !== exp_rdata[sel]) begin
                    n_fail++;
                    $display("FAIL %s rdata: got %h, required %h", name, obs_rdata,
                             exp_rdata[sel]);
                end
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ResetPins) begin
            n_fail++;
            $display("FAIL reset pins: got %h, required %h", obs, ResetPins);
        end
        n_cmp++;
        if (rdata_a !== 16'h0 || rdata_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset rdata: got %h/%h, required 0000/0000", rdata_a, rdata_b);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        n_cmp++;
        if (ready_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready_before_edge: got %b, required 0", ready_a);
        end
        @(negedge Clk);
        n_cmp++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL reset ready_after_edge: got %b/%b, required 1/1", ready_a, ready_b);
        end
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
    endtask

    task automatic test_reg_write();
        sel = 1'b0;
        run_op(1'b1, 1'b0, 2'd1, 16'($urandom), 16'hCE00, 16'($urandom), "reg_write");
    endtask

    task automatic test_reg_read();
        sel = 1'b0;
        run_op(1'b0, 1'b0, 2'd3, 16'($urandom), 16'($urandom), 16'h1234, "reg_read");
    endtask

    task automatic test_mem_write();
        sel = 1'b0;
        run_op(1'b1, 1'b1, 2'($urandom), 16'h0514, 16'hBEEF, 16'($urandom), "mem_write");
    endtask

    task automatic test_mem_read();
        sel = 1'b0;
        run_op(1'b0, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom) | 16'h1,
               "mem_read");
    endtask

    task automatic test_back_to_back();
        bit exp_rdy, exp_vld;
        sel = 1'b0;
        cmd_write = 1'b0; cmd_mem = 1'b0; cmd_reg = 2'($urandom);
        cmd_addr = 16'($urandom); cmd_wdata = 16'($urandom);
        pad_val = 16'($urandom);
        exp_rdata[0] = pad_val;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && ready_a !== 1'b1; i++) @(negedge Clk);
        n_cmp++;
        if (ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b first_accept: cmd_ready=%b, required 1", ready_a);
        end
        for (int c = 1; c <= 30; c++) begin
            @(negedge Clk);
            exp_rdy = (c == 10 || c == 20 || c == 30);
            exp_vld = (c == 9 || c == 19 || c == 29);
            n_cmp++;
            if ({ready_a, valid_a} !== {exp_rdy, exp_vld}) begin
                n_fail++;
                $display("FAIL b2b handshake cycle %0d: ready/valid got %b%b, required %b%b",
                         c, ready_a, valid_a, exp_rdy, exp_vld);
            end
            n_cmp++;
            if (!(r_a === 1'b1 || w_a === 1'b1)) begin
                n_fail++;
                $display("FAIL b2b strobes cycle %0d: r/w got %b%b, required not both 0",
                         c, r_a, w_a);
            end
            if (exp_vld) begin
                n_cmp++;
                if (rdata_a !== exp_rdata[0]) begin
                    n_fail++;
                    $display("FAIL b2b rdata cycle %0d: got %h, required %h", c, rdata_a,
                             exp_rdata[0]);
                end
            end
            if (c == 20) begin
                @(posedge Clk);
                #1 cmd_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        sel = 1'b0;
        seen = 1'b0;
        cmd_write = 1'b0; cmd_mem = 1'b1; cmd_reg = 2'($urandom);
        cmd_addr = 16'($urandom); cmd_wdata = 16'($urandom);
        pad_val = 16'($urandom);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && ready_a !== 1'b1; i++) @(negedge Clk);
        @(posedge Clk);
        #1 cmd_valid = 1'b0;
        // Cycle 11 is inside the DATA-phase read strobe.
        repeat (11) @(negedge Clk);
        n_cmp++;
        if (r_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid strobe_active: hpi_r got %b, required 0", r_a);
        end
        #2 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== ResetPins || rdata_a !== 16'h0) begin
            n_fail++;
            $display("FAIL rst_mid immediate: pins %h rdata %h, required %h 0000", obs,
                     rdata_a, ResetPins);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            n_cmp++;
            if (obs !== ResetPins) begin
                n_fail++;
                $display("FAIL rst_mid held: got %h, required %h", obs, ResetPins);
            end
        end
        Reset_n = 1'b1;
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (valid_a === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen || obs !== IdlePins) begin
            n_fail++;
            $display("FAIL rst_mid aftermath: rsp_valid seen %b, pins %h, required 0 %h",
                     seen, obs, IdlePins);
        end
        run_op(1'b0, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               "rst_mid_next");
    endtask

    task automatic test_fast();
        sel = 1'b1;
        run_op(1'b1, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               "fast_reg_write");
        run_op(1'b0, 1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               "fast_reg_read");
        run_op(1'b0, 1'b1, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
               "fast_mem_read");
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            sel = 1'($urandom);
            run_op(1'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), "random");
        end
        sel = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        exp_rdata[0] = 16'h0;
        exp_rdata[1] = 16'h0;
        test_reset();
        test_reg_write();
        test_reg_read();
        test_mem_write();
        test_mem_read();
        test_back_to_back();
        test_reset_mid_op();
        test_fast();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hpi_txn_ctrl.md
HPI_TXN_CTRL -- requirements
Module: hpi_txn_ctrl

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 4: cycles the read/write strobe is held low (range 1-15).
REQ-002 SHALL have parameter RECOVER_CYCLES, default 2: cycles chip-select is held high between accesses (range 1-15).
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted on the edge where cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port cmd_mem, input, 1 bit: 1 = memory op (address phase, then data phase); 0 = single register op.
REQ-009 SHALL have port cmd_reg, input, 2 bits: HPI register for a register op (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
REQ-010 SHALL have port cmd_addr, input, 16 bits: CY7C67200 memory address for a memory op.
REQ-011 SHALL have port cmd_wdata, input, 16 bits: write data.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 16 bits: read result, valid while rsp_valid is high.
REQ-014 SHALL have port hpi_address, output, 2 bits: to the HPI pad interface address input.
REQ-015 SHALL have port hpi_data_out, output, 16 bits: to the pad interface write data.
REQ-016 SHALL have port hpi_data_in, input, 16 bits: registered read data from the pad interface.
REQ-017 SHALL have ports hpi_r, hpi_w, and hpi_cs, outputs, 1 bit each: active-low strobes and chip-select to the pad interface.

Function
REQ-018 SHALL latch all cmd_* fields on acceptance; later changes to the inputs SHALL have no effect until the next acceptance.
REQ-019 SHALL assert cmd_ready only in IDLE.
REQ-020 SHALL implement the states IDLE, SETUP, STROBE, HOLD, RECOVER and DONE; each access phase SHALL take the path SETUP(1) -> STROBE(STROBE_CYCLES) -> HOLD(1) -> RECOVER(RECOVER_CYCLES).
REQ-021 In SETUP, STROBE and HOLD: hpi_cs = 0, hpi_address driven; hpi_data_out SHALL equal the phase write data, else 0.
REQ-022 In STROBE only: hpi_r = 0 for a read phase, or hpi_w = 0 for a write phase; never both; both SHALL be 1 in every other state.
REQ-023 In IDLE, RECOVER and DONE: hpi_cs = 1, hpi_r = 1, hpi_w = 1, hpi_address = 0.
REQ-024 On a read phase, SHALL capture hpi_data_in into rsp_rdata in HOLD, compensating the pad interface's one-cycle output and input registering.
REQ-025 A register op SHALL be one phase on cmd_reg.
REQ-026 A memory op SHALL be two phases:
- phase 1: write cmd_addr to ADDRESS (2);
- phase 2: read or write DATA (0).
REQ-027 The STROBE and RECOVER counters SHALL be 4-bit down-counters, loaded with parameter-1 on state entry; the state exits when the count is 0.
REQ-028 Acceptance edge = cycle 0. A register op SHALL reach DONE at cycle STROBE_CYCLES+RECOVER_CYCLES+3 (9 with defaults). A memory op SHALL reach DONE at cycle 2*(STROBE_CYCLES+RECOVER_CYCLES)+5 (17 with defaults).
REQ-029 rsp_valid SHALL be high exactly in DONE; DONE SHALL go to IDLE unconditionally; there SHALL be no backpressure on the response.
REQ-030 On a write op, rsp_rdata SHALL hold its previous value.
REQ-031 cmd_valid held high continuously SHALL yield back-to-back ops, each separated by exactly one IDLE cycle.

Reset
REQ-032 Reset_n = 0 SHALL immediately, regardless of Clk, force:
- state IDLE, counters 0;
- hpi_cs, hpi_r, hpi_w = 1;
- hpi_address = 0, hpi_data_out = 0;
- rsp_valid = 0, rsp_rdata = 0.
REQ-033 cmd_ready SHALL be 0 while Reset_n = 0 and SHALL be 1 from the first edge after release.
REQ-034 Reset mid-operation SHALL abort the op with no rsp_valid and no strobe glitch; the next command after release SHALL run normally.

Verification
REQ-035 Register write: MAILBOX (1), wdata 16'hCE00 -> hpi_w low cycles 2-5, hpi_cs low cycles 1-6, hpi_address 1, rsp_valid at cycle 9.
REQ-036 Register read: STATUS (3), pad model returns 16'h1234 -> hpi_r low cycles 2-5, rsp_rdata 16'h1234 with rsp_valid at cycle 9.
REQ-037 Memory write: addr 16'h0514, wdata 16'hBEEF -> phase 1 writes 16'h0514 to address 2, phase 2 writes 16'hBEEF to address 0, hpi_cs high for two cycles between phases, rsp_valid at cycle 17.
REQ-038 Back-to-back: cmd_valid held high for 3 register ops -> accepts at cycles 0, 10, 20; never hpi_r and hpi_w both low.
REQ-039 Reset_n pulsed low during STROBE of a memory read -> outputs at reset values within the same cycle, no rsp_valid, next op completes with correct data.
REQ-040 STROBE_CYCLES = 1, RECOVER_CYCLES = 1 -> register op rsp_valid at cycle 5, strobe low exactly one cycle.
